// File: rtl/queue_calc_pkg.sv
// Shared types for the queue calculator: opcodes, error codes and FSM states.
package queue_calc_pkg;

   typedef enum logic [2:0] {
      OP_PUSH  = 3'd0,
      OP_POP   = 3'd1,
      OP_ADD   = 3'd2,
      OP_SUB   = 3'd3,
      OP_MUL   = 3'd4,
      OP_DIV   = 3'd5,
      OP_MOD   = 3'd6,
      OP_CLEAR = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_UNDERFLOW = 2'd1,
      ERR_OVERFLOW  = 2'd2,
      ERR_DIV0      = 2'd3
   } err_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/queue_calc_param_if.sv
// Command/status bundle between the host and the queue calculator.
interface queue_calc_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] in;
   logic [2:0]       op;
   logic             apply;
   logic             ready;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             done;
   logic [1:0]       err;

   modport master (
      output in, op, apply,
      input  ready, head, tail, count, empty, full, done, err
   );

   modport slave (
      input  in, op, apply,
      output ready, head, tail, count, empty, full, done, err
   );
endinterface

// File: rtl/queue_calc_param_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so results are stable WIDTH-1 cycles later.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CNTW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] src_quo, src_rem;
   logic [WIDTH:0]   shifted, diff;

   assign busy      = (cnt_q != '0);
   assign quotient  = quo_q;
   assign remainder = rem_q;

   always_comb begin
      src_quo = start ? dividend : quo_q;
      src_rem = start ? '0 : rem_q;
      dvs_d   = start ? divisor : dvs_q;
      shifted = {src_rem, src_quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_d};
      quo_d   = quo_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      if (start) begin
         cnt_d = CNTW'(WIDTH - 1);
      end else if (busy) begin
         cnt_d = cnt_q - CNTW'(1);
      end
      if (start || busy) begin
         // diff[WIDTH] is the borrow: set means the trial subtraction failed
         if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {src_quo[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {src_quo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/queue_calc_param.sv
// Queue calculator: ring buffer of operands, single-cycle ALU ops and a
// multi-cycle DIV/MOD path through seq_divider.
module queue_calc_param
   import queue_calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic               clk,
   input logic               rst,
   queue_calc_param_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   state_e           state_q, state_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             done_q, done_d;
   err_e             err_q, err_d;
   op_e              op_q, op_d, op_sel;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             mem_we, div_start, div_busy, is_binary, empty_w, full_w;
   logic [WIDTH-1:0] mem_wdata, opa, opb, tail_val, alu, quo, rem;

   assign op_sel    = op_e'(bus.op);
   assign opa       = mem_q[rd_ptr_q];
   assign opb       = mem_q[rd_ptr_q + PW'(1)];
   assign tail_val  = mem_q[wr_ptr_q - PW'(1)];
   assign empty_w   = (count_q == '0);
   assign full_w    = (count_q == CW'(DEPTH));
   assign is_binary = op_sel inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD};

   assign bus.ready = (state_q == S_IDLE);
   assign bus.head  = empty_w ? '0 : opa;
   assign bus.tail  = empty_w ? '0 : tail_val;
   assign bus.count = count_q;
   assign bus.empty = empty_w;
   assign bus.full  = full_w;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

   always_comb begin
      alu = '0;
      case (op_sel)
         OP_ADD:  alu = opa + opb;
         OP_SUB:  alu = opa - opb;
         OP_MUL:  alu = opa * opb;
         default: alu = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      done_d    = 1'b0;
      err_d     = err_q;
      op_d      = op_q;
      mem_we    = 1'b0;
      mem_wdata = bus.in;
      div_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.apply) begin
               if ((op_sel == OP_POP && empty_w) || (is_binary && count_q < CW'(2))) begin
                  err_d  = ERR_UNDERFLOW;
                  done_d = 1'b1;
               end else if (op_sel == OP_PUSH && full_w) begin
                  err_d  = ERR_OVERFLOW;
                  done_d = 1'b1;
               end else if ((op_sel == OP_DIV || op_sel == OP_MOD) && opb == '0) begin
                  err_d  = ERR_DIV0;
                  done_d = 1'b1;
               end else begin
                  err_d = ERR_NONE;
                  case (op_sel)
                     OP_PUSH: begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        count_d  = count_q + CW'(1);
                        done_d   = 1'b1;
                     end
                     OP_POP: begin
                        rd_ptr_d = rd_ptr_q + PW'(1);
                        count_d  = count_q - CW'(1);
                        done_d   = 1'b1;
                     end
                     OP_DIV, OP_MOD: begin
                        div_start = 1'b1;
                        op_d      = op_sel;
                        state_d   = S_BUSY;
                     end
                     OP_CLEAR: begin
                        rd_ptr_d = '0;
                        wr_ptr_d = '0;
                        count_d  = '0;
                        done_d   = 1'b1;
                     end
                     default: begin
                        mem_we    = 1'b1;
                        mem_wdata = alu;
                        rd_ptr_d  = rd_ptr_q + PW'(2);
                        wr_ptr_d  = wr_ptr_q + PW'(1);
                        count_d   = count_q - CW'(1);
                        done_d    = 1'b1;
                     end
                  endcase
               end
            end
         end
         S_BUSY: begin
            // Queue is frozen while busy, so the pointers still address the operands
            if (!div_busy) begin
               mem_we    = 1'b1;
               mem_wdata = (op_q == OP_DIV) ? quo : rem;
               rd_ptr_d  = rd_ptr_q + PW'(2);
               wr_ptr_d  = wr_ptr_q + PW'(1);
               count_d   = count_q - CW'(1);
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= ERR_NONE;
         op_q     <= OP_DIV;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         done_q   <= done_d;
         err_q    <= err_d;
         op_q     <= op_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
   end

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (opa),
      .divisor   (opb),
      .busy      (div_busy),
      .quotient  (quo),
      .remainder (rem)
   );
endmodule

// File: tb/tb_queue_calc_param.sv
// Directed bench for queue_calc_param (WIDTH=8, DEPTH=4) with a done-driven scoreboard.
module tb_queue_calc_param;
   import queue_calc_pkg::*;

   typedef struct {
      string      name;
      logic [1:0] err;
      logic [7:0] head;
      logic [7:0] tail;
      logic [2:0] count;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   queue_calc_param_if #(.WIDTH(8), .DEPTH(4)) bus ();
   queue_calc_param #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(bus.done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("done %-10s err=%0d head=%0d tail=%0d count=%0d", e.name, bus.err, bus.head, bus.tail, bus.count);
            chk({e.name, ".err"},   32'(bus.err),   32'(e.err));
            chk({e.name, ".head"},  32'(bus.head),  32'(e.head));
            chk({e.name, ".tail"},  32'(bus.tail),  32'(e.tail));
            chk({e.name, ".count"}, 32'(bus.count), 32'(e.count));
         end
      end
   end

   task automatic issue(input string name, input logic [2:0] o, input logic [7:0] v, input bit want,
                        input logic [1:0] e_err, input logic [7:0] e_head, input logic [7:0] e_tail,
                        input logic [2:0] e_count);
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!bus.ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ready) chk({name, ".ready_timeout"}, 32'(bus.ready), 32'd1);
      bus.op    = o;
      bus.in    = v;
      bus.apply = 1'b1;
      if (want) begin
         e.name = name; e.err = e_err; e.head = e_head; e.tail = e_tail; e.count = e_count;
         sb.push_back(e);
      end
      @(posedge clk);
      #1 bus.apply = 1'b0;
   endtask

   // Counts busy cycles after a DIV/MOD acceptance; optionally strobes a PUSH while busy
   task automatic watch_busy(input string name, input bit poke, input int exp_cycles);
      int low = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready) break;
         low++;
         if (poke && low == 3) begin
            bus.op = OP_PUSH; bus.in = 8'd55; bus.apply = 1'b1;
         end
      end
      bus.apply = 1'b0;
      chk({name, ".busy_cycles"}, 32'(low), 32'(exp_cycles));
   endtask

   initial begin
      bus.apply = 1'b0;
      bus.op    = 3'd0;
      bus.in    = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.empty", 32'(bus.empty), 32'd1);
      chk("rst.count", 32'(bus.count), 32'd0);
      chk("rst.ready", 32'(bus.ready), 32'd1);
      chk("rst.tail",  32'(bus.tail),  32'd0);
      chk("rst.head",  32'(bus.head),  32'd0);
      chk("rst.err",   32'(bus.err),   32'd0);
      chk("rst.done",  32'(bus.done),  32'd0);
      chk("rst.full",  32'(bus.full),  32'd0);
      rst = 1'b0;

      issue("push7",   OP_PUSH, 8'd7,   1, ERR_NONE, 8'd7,   8'd7,   3'd1);
      issue("push3",   OP_PUSH, 8'd3,   1, ERR_NONE, 8'd7,   8'd3,   3'd2);
      issue("sub",     OP_SUB,  8'd0,   1, ERR_NONE, 8'd4,   8'd4,   3'd1);
      issue("clear1",  OP_CLEAR,8'd0,   1, ERR_NONE, 8'd0,   8'd0,   3'd0);
      issue("push200", OP_PUSH, 8'd200, 1, ERR_NONE, 8'd200, 8'd200, 3'd1);
      issue("push100", OP_PUSH, 8'd100, 1, ERR_NONE, 8'd200, 8'd100, 3'd2);
      issue("add",     OP_ADD,  8'd0,   1, ERR_NONE, 8'd44,  8'd44,  3'd1);
      issue("pop1",    OP_POP,  8'd0,   1, ERR_NONE, 8'd0,   8'd0,   3'd0);
      issue("push20",  OP_PUSH, 8'd20,  1, ERR_NONE, 8'd20,  8'd20,  3'd1);
      issue("push13",  OP_PUSH, 8'd13,  1, ERR_NONE, 8'd20,  8'd13,  3'd2);
      issue("mul",     OP_MUL,  8'd0,   1, ERR_NONE, 8'd4,   8'd4,   3'd1);
      issue("pop2",    OP_POP,  8'd0,   1, ERR_NONE, 8'd0,   8'd0,   3'd0);

      issue("push100", OP_PUSH, 8'd100, 1, ERR_NONE, 8'd100, 8'd100, 3'd1);
      issue("push7",   OP_PUSH, 8'd7,   1, ERR_NONE, 8'd100, 8'd7,   3'd2);
      issue("div",     OP_DIV,  8'd0,   1, ERR_NONE, 8'd14,  8'd14,  3'd1);
      watch_busy("div", 1'b1, 8);
      issue("pop3",    OP_POP,  8'd0,   1, ERR_NONE, 8'd0,   8'd0,   3'd0);
      issue("push100", OP_PUSH, 8'd100, 1, ERR_NONE, 8'd100, 8'd100, 3'd1);
      issue("push7",   OP_PUSH, 8'd7,   1, ERR_NONE, 8'd100, 8'd7,   3'd2);
      issue("mod",     OP_MOD,  8'd0,   1, ERR_NONE, 8'd2,   8'd2,   3'd1);
      watch_busy("mod", 1'b0, 8);
      issue("pop4",    OP_POP,  8'd0,   1, ERR_NONE, 8'd0,   8'd0,   3'd0);

      issue("push5",   OP_PUSH, 8'd5,   1, ERR_NONE, 8'd5,   8'd5,   3'd1);
      issue("push0",   OP_PUSH, 8'd0,   1, ERR_NONE, 8'd5,   8'd0,   3'd2);
      issue("div0",    OP_DIV,  8'd0,   1, ERR_DIV0, 8'd5,   8'd0,   3'd2);
      @(negedge clk);
      chk("div0.ready", 32'(bus.ready), 32'd1);
      @(negedge clk);
      chk("div0.err_held", 32'(bus.err),  32'd3);
      chk("div0.done_low", 32'(bus.done), 32'd0);
      issue("clear2",  OP_CLEAR,8'd0,   1, ERR_NONE, 8'd0,   8'd0,   3'd0);
      @(negedge clk);
      chk("clear2.empty", 32'(bus.empty), 32'd1);
      issue("add_uf",  OP_ADD,  8'd0,   1, ERR_UNDERFLOW, 8'd0, 8'd0, 3'd0);
      issue("pop_uf",  OP_POP,  8'd0,   1, ERR_UNDERFLOW, 8'd0, 8'd0, 3'd0);

      issue("push1",   OP_PUSH, 8'd1,   1, ERR_NONE, 8'd1,   8'd1,   3'd1);
      issue("push2",   OP_PUSH, 8'd2,   1, ERR_NONE, 8'd1,   8'd2,   3'd2);
      issue("push3",   OP_PUSH, 8'd3,   1, ERR_NONE, 8'd1,   8'd3,   3'd3);
      issue("push4",   OP_PUSH, 8'd4,   1, ERR_NONE, 8'd1,   8'd4,   3'd4);
      issue("push_of", OP_PUSH, 8'd5,   1, ERR_OVERFLOW, 8'd1, 8'd4,  3'd4);
      @(negedge clk);
      chk("push_of.full", 32'(bus.full), 32'd1);
      issue("pop5",    OP_POP,  8'd0,   1, ERR_NONE, 8'd2,   8'd4,   3'd3);
      issue("push9",   OP_PUSH, 8'd9,   1, ERR_NONE, 8'd2,   8'd9,   3'd4);
      issue("add_wrap",OP_ADD,  8'd0,   1, ERR_NONE, 8'd4,   8'd5,   3'd3);

      // Reset during a division: no done may follow
      issue("div_rst", OP_DIV,  8'd0,   0, ERR_NONE, 8'd0,   8'd0,   3'd0);
      repeat (3) @(negedge clk);
      chk("div_rst.busy", 32'(bus.ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("div_rst.ready", 32'(bus.ready), 32'd1);
      chk("div_rst.empty", 32'(bus.empty), 32'd1);
      chk("div_rst.count", 32'(bus.count), 32'd0);
      chk("div_rst.done",  32'(bus.done),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("post_rst.ready", 32'(bus.ready), 32'd1);
      chk("post_rst.count", 32'(bus.count), 32'd0);

      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end
endmodule
